ram_lsu: RTL

Parametrised, byte-addressed data memory for the RISC core's load/store path. Successor to the plain word RAM, and adds:
- a valid/ready request handshake;
- byte/half/word (and double, for 64-bit) access with sign or zero extension;
- byte-lane write masking and misalignment error reporting;
- configurable read latency;
- self-clearing of the whole array after reset.

One request is accepted per cycle, and exactly one in-order response is produced per request.

---
 rtl/ram_lsu.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: byte-addressed data memory for the load/store path.
// Accepts one valid/ready request per cycle and returns one in-order response
// READ_LATENCY cycles later. Loads are extended to the full word, stores apply
// a byte-lane mask, and misaligned or illegal-size requests report rsp_err.
// After every reset the whole array is zeroed before req_ready rises.
module ram_lsu #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(NB);
    localparam int IDX_W = ADDR_WIDTH - OFFS;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        clear_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [OFFS-1:0]         off;
    logic [IDX_W-1:0]        idx;
    logic                    accept;
    logic                    misaligned;
    logic                    bad_size;
    logic                    err;
    logic [NB-1:0]           lane_base;
    logic [NB-1:0]           be;
    logic [DATA_WIDTH-1:0]   wdata_sh;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   load_val;

    logic                    vld_p   [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   rdata_p [READ_LATENCY];
    logic                    err_p   [READ_LATENCY];

    // Shift the addressed lane down to bit 0 and sign/zero-extend it.
    // A full-word access returns the word unchanged whatever req_unsigned says.
    function automatic logic [DATA_WIDTH-1:0] extend_lane(
        input logic [DATA_WIDTH-1:0] word,
        input logic [OFFS-1:0]       lane_off,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0]        lane;
        logic signed [7:0]            s8;
        logic signed [15:0]           s16;
        logic signed [31:0]           s32;
        logic signed [DATA_WIDTH-1:0] sext;
        logic [DATA_WIDTH-1:0]        result;
        lane   = word >> {lane_off, 3'b000};
        s8     = lane[7:0];
        s16    = lane[15:0];
        s32    = lane[31:0];
        sext   = '0;
        result = lane;
        case (size)
            2'b00: begin
                sext   = s8;
                result = uns ? DATA_WIDTH'(lane[7:0]) : sext;
            end
            2'b01: begin
                sext   = s16;
                result = uns ? DATA_WIDTH'(lane[15:0]) : sext;
            end
            2'b10: begin
                sext   = s32;
                result = uns ? DATA_WIDTH'(lane[31:0]) : sext;
            end
            default: result = lane;
        endcase
        return result;
    endfunction

    assign off      = req_addr[OFFS-1:0];
    assign idx      = req_addr[ADDR_WIDTH-1:OFFS];
    assign accept   = req_valid & req_ready;
    assign bad_size = (req_size == 2'b11) && (DATA_WIDTH == 32);
    assign err      = misaligned | bad_size;
    assign be       = lane_base << off;
    assign wdata_sh = req_wdata << {off, 3'b000};
    assign rd_word  = mem[idx];
    assign load_val = extend_lane(rd_word, off, req_size, req_unsigned);

    // Alignment check and base byte-enable pattern for the access size.
    always_comb begin
        misaligned = 1'b0;
        lane_base  = '1;
        case (req_size)
            2'b00: begin
                misaligned = 1'b0;
                lane_base  = NB'(1);
            end
            2'b01: begin
                misaligned = off[0];
                lane_base  = NB'(3);
            end
            2'b10: begin
                misaligned = |off[1:0];
                lane_base  = NB'(15);
            end
            default: begin
                misaligned = |off;
                lane_base  = '1;
            end
        endcase
    end

    // Control FSM: sweep the array to zero after reset, then accept forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (&clear_cnt) begin
                        state     <= READY;
                        req_ready <= 1'b1;
                    end
                end
                default: req_ready <= 1'b1;
            endcase
        end
    end

    // Memory array: zero-fill during CLEAR, masked byte writes for good stores.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (accept && req_we && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Response valid pipeline; reset drops every in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Response data pipeline; stores and errors carry zero data.
    always_ff @(posedge clk) begin
        rdata_p[0] <= (err || req_we) ? '0 : load_val;
        err_p[0]   <= err;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rdata_p[i] <= rdata_p[i-1];
            err_p[i]   <= err_p[i-1];
        end
    end

    assign rsp_valid = vld_p[READ_LATENCY-1];
    assign rsp_rdata = rsp_valid ? rdata_p[READ_LATENCY-1] : '0;
    assign rsp_err   = rsp_valid & err_p[READ_LATENCY-1];

endmodule
